// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch/core definitions: FSM encoding, alignment mask, default boot PC.
package cpu_defs;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_REDIR = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Force an address onto a word boundary.
    function automatic logic [31:0] align_addr(input logic [31:0] addr);
        return addr & INSTR_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_mux.sv
// Next-PC selection for the fetch stage (purely combinational).
// Branch (older instr, resolved in EX) beats jump (ID); any redirect beats stall.
module next_pc_mux
    import cpu_defs::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic [31:0] redirect_target,
    output logic        misalign
);

    logic [31:0] raw_target;

    // Pick the redirect source and align it; flag any dropped low bits.
    always_comb begin
        raw_target      = branch_taken ? branch_target : jump_target;
        redirect        = branch_taken | jump;
        redirect_target = align_addr(raw_target);
        misalign        = redirect & (raw_target[1:0] != 2'b00);
    end

    // PC only moves when imem has completed the current request.
    always_comb begin
        next_pc = pc;
        if (imem_ready) begin
            if (redirect)
                next_pc = redirect_target;
            else if (!stall)
                next_pc = pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer for the 5-stage core.
// Holds imem_addr stable across an unfinished request; a redirect that arrives
// while imem is busy is parked in pend_pc and applied when the request completes.
module fetch_sequencer
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        if_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic        flush_if,
    output logic        flush_id,
    output logic        misalign
);

    fetch_state_e state, state_next;
    logic [31:0]  pend_pc, pend_pc_next, pc_next;

    logic [31:0]  mux_next_pc, redirect_target;
    logic         redirect, mux_misalign;

    next_pc_mux u_next_pc_mux (
        .pc              (pc),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .jump            (jump),
        .jump_target     (jump_target),
        .stall           (stall),
        .imem_ready      (imem_ready),
        .next_pc         (mux_next_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .misalign        (mux_misalign)
    );

    assign imem_addr = pc;
    assign pc_plus_4 = pc + 32'd4;

    // State, PC and parked redirect target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_BOOT;
            pc      <= RESET_PC;
            pend_pc <= 32'h0000_0000;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            pend_pc <= pend_pc_next;
        end
    end

    // Next-state and fetch/flush outputs.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        pend_pc_next = pend_pc;
        imem_req     = 1'b0;
        if_valid     = 1'b0;
        flush_if     = 1'b0;
        flush_id     = 1'b0;
        misalign     = 1'b0;
        case (state)
            S_BOOT: begin
                // One idle cycle out of reset before the first request.
                state_next = S_RUN;
            end
            S_RUN: begin
                imem_req = 1'b1;
                flush_if = redirect;
                flush_id = branch_taken;
                misalign = mux_misalign;
                if (redirect && !imem_ready) begin
                    pend_pc_next = redirect_target;
                    state_next   = S_REDIR;
                end else begin
                    pc_next = mux_next_pc;
                end
                if_valid = imem_ready & ~redirect & ~stall;
            end
            S_REDIR: begin
                // Everything fetched here is wrong-path; if_valid stays low.
                imem_req = 1'b1;
                flush_if = redirect;
                flush_id = branch_taken;
                misalign = mux_misalign;
                if (redirect)
                    pend_pc_next = redirect_target;
                if (imem_ready) begin
                    // A redirect arriving on the completing cycle is the newest one.
                    pc_next    = redirect ? redirect_target : pend_pc;
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump, imem_ready;
    logic [31:0] branch_target, jump_target;

    logic        imem_req, if_valid, flush_if, flush_id, misalign;
    logic [31:0] imem_addr, pc, pc_plus_4;

    logic        b_imem_req, b_if_valid, b_flush_if, b_flush_id, b_misalign;
    logic [31:0] b_imem_addr, b_pc, b_pc_plus_4;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          chk;
        bit          req;
        logic [31:0] addr;
        bit          ifv, fi, fid, mis;
        bit          chkb;
        logic [31:0] baddr;
        logic [31:0] bpp4;
    } exp_t;

    exp_t sbq[$];

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .if_valid(if_valid), .pc(pc), .pc_plus_4(pc_plus_4),
        .flush_if(flush_if), .flush_id(flush_id), .misalign(misalign)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ready(imem_ready),
        .if_valid(b_if_valid), .pc(b_pc), .pc_plus_4(b_pc_plus_4),
        .flush_if(b_flush_if), .flush_id(b_flush_id), .misalign(b_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.chk) begin
                check("imem_req",  {31'd0, imem_req}, {31'd0, e.req});
                check("imem_addr", imem_addr, e.addr);
                check("pc",        pc, e.addr);
                check("pc_plus_4", pc_plus_4, e.addr + 32'd4);
                check("if_valid",  {31'd0, if_valid}, {31'd0, e.ifv});
                check("flush_if",  {31'd0, flush_if}, {31'd0, e.fi});
                check("flush_id",  {31'd0, flush_id}, {31'd0, e.fid});
                check("misalign",  {31'd0, misalign}, {31'd0, e.mis});
            end
            if (e.chkb) begin
                check("wrap_addr", b_imem_addr, e.baddr);
                check("wrap_pp4",  b_pc_plus_4, e.bpp4);
            end
        end
    end

    // Apply one cycle of inputs and queue what DUT should show this cycle.
    task automatic step(input bit r, input bit st, input bit br, input logic [31:0] bt,
                        input bit j, input logic [31:0] jt, input bit rdy,
                        input bit chk, input bit req, input logic [31:0] addr,
                        input bit ifv, input bit fi, input bit fid, input bit mis);
        exp_t e;
        rst = r; stall = st; branch_taken = br; branch_target = bt;
        jump = j; jump_target = jt; imem_ready = rdy;
        e.chk = chk; e.req = req; e.addr = addr; e.ifv = ifv;
        e.fi = fi; e.fid = fid; e.mis = mis;
        e.chkb = 1'b0; e.baddr = 32'd0; e.bpp4 = 32'd0;
        sbq.push_back(e);
        @(posedge clk); #1;
    endtask

    // Same as a plain sequential step, additionally checking the wrap instance.
    task automatic step_b(input bit r, input logic [31:0] addr, input bit req, input bit ifv,
                          input logic [31:0] baddr, input logic [31:0] bpp4);
        exp_t e;
        rst = r; stall = 0; branch_taken = 0; branch_target = 0;
        jump = 0; jump_target = 0; imem_ready = 1;
        e.chk = 1; e.req = req; e.addr = addr; e.ifv = ifv;
        e.fi = 0; e.fid = 0; e.mis = 0;
        e.chkb = 1; e.baddr = baddr; e.bpp4 = bpp4;
        sbq.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1; stall = 0; branch_taken = 0; branch_target = 0;
        jump = 0; jump_target = 0; imem_ready = 1;
        @(posedge clk); #1;
        // reset, state unknown before first edge
        step(1,0,0,0,0,0,1, 0,0,32'h0,0,0,0,0);
        // reset held: boot state
        step_b(1, 32'h0, 0, 0, 32'hFFFF_FFFC, 32'h0);
        // release: boot cycle, no request
        step_b(0, 32'h0, 0, 0, 32'hFFFF_FFFC, 32'h0);
        // sequential fetch; wrap instance rolls over to 0
        step_b(0, 32'h0, 1, 1, 32'hFFFF_FFFC, 32'h0);
        step_b(0, 32'h4, 1, 1, 32'h0, 32'h4);
        step(0,0,0,0,0,0,1, 1,1,32'h8,1,0,0,0);
        step(0,0,0,0,0,0,1, 1,1,32'hC,1,0,0,0);
        // stall 3 cycles at 0x10
        step(0,1,0,0,0,0,1, 1,1,32'h10,0,0,0,0);
        step(0,1,0,0,0,0,1, 1,1,32'h10,0,0,0,0);
        step(0,1,0,0,0,0,1, 1,1,32'h10,0,0,0,0);
        step(0,0,0,0,0,0,1, 1,1,32'h10,1,0,0,0);
        step(0,0,0,0,0,0,1, 1,1,32'h14,1,0,0,0);
        step(0,0,0,0,0,0,1, 1,1,32'h18,1,0,0,0);
        step(0,0,0,0,0,0,1, 1,1,32'h1C,1,0,0,0);
        // branch and jump together at 0x20: branch wins
        step(0,0,1,32'h100,1,32'h200,1, 1,1,32'h20,0,1,1,0);
        step(0,0,0,0,0,0,1, 1,1,32'h100,1,0,0,0);
        // jump to 0x40 with imem ready
        step(0,0,0,0,1,32'h40,1, 1,1,32'h104,0,1,0,0);
        // jump while imem busy: address held, redirect parked
        step(0,0,0,0,1,32'h80,0, 1,1,32'h40,0,1,0,0);
        step(0,0,0,0,0,0,0, 1,1,32'h40,0,0,0,0);
        step(0,0,0,0,0,0,1, 1,1,32'h40,0,0,0,0);
        step(0,0,0,0,0,0,1, 1,1,32'h80,1,0,0,0);
        // misaligned branch target
        step(0,0,1,32'h103,0,0,1, 1,1,32'h84,0,1,1,1);
        step(0,0,0,0,0,0,1, 1,1,32'h100,1,0,0,0);
        // parked jump overwritten by a later branch (branch beats jump)
        step(0,0,0,0,1,32'h300,0, 1,1,32'h104,0,1,0,0);
        step(0,0,1,32'h200,1,32'h300,0, 1,1,32'h104,0,1,1,0);
        step(0,0,0,0,0,0,0, 1,1,32'h104,0,0,0,0);
        step(0,0,0,0,0,0,1, 1,1,32'h104,0,0,0,0);
        step(0,0,0,0,0,0,1, 1,1,32'h200,1,0,0,0);
        // reset while a redirect is parked
        step(0,0,0,0,1,32'h400,0, 1,1,32'h204,0,1,0,0);
        step(1,0,0,0,0,0,0, 1,1,32'h204,0,0,0,0);
        step(0,0,0,0,0,0,1, 1,0,32'h0,0,0,0,0);
        step(0,0,0,0,0,0,1, 1,1,32'h0,1,0,0,0);
        // redirect overrides stall
        step(0,1,1,32'h50,0,0,1, 1,1,32'h4,0,1,1,0);
        step(0,0,0,0,0,0,1, 1,1,32'h50,1,0,0,0);
        step(0,0,0,0,0,0,1, 1,1,32'h54,1,0,0,0);
        repeat (2) @(posedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
